jsilicon_core_p: RTL

Parametrised successor to the fixed 4-bit ALU/UART core: a start-strobed execution engine with an operand width of `DATA_W`. It latches two operands and a 3-bit opcode, then executes single-cycle ops or a multi-cycle shift-add multiply. It holds the `2*DATA_W`-bit result and serialises it LSB-byte-first over an 8N1 UART TX with a configurable bit period. It sits directly under the TinyTapeout top wrapper, which maps pins onto its ports.

---
 rtl/jsilicon_core_p.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/jsilicon_core_p.sv
// jsilicon_core_p: start-strobed ALU / shift-add multiplier whose 2*DATA_W-bit result is sent LSB byte first.
// Define JSILICON_UART_EN to build the 8N1 transmitter; without it tx is tied high and DONE follows execution.
module jsilicon_core_p #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [2:0]          opcode,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] result,
  output logic                tx
);
  localparam int unsigned RW = 2 * DATA_W;
  localparam int MCW = $clog2(DATA_W) + 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
`ifdef JSILICON_UART_EN
    S_TX   = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]          op_q, op_d;
  logic [RW-1:0]       result_q, result_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic [RW-1:0]       acc_q, acc_d, mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
  logic [MCW-1:0]      mcnt_q, mcnt_d;

  logic [RW-1:0]       exec_res, mul_sum, fin_res, a_ext, b_ext;
  logic [31:0]         shamt;
  logic                fin;

`ifdef JSILICON_UART_EN
  localparam int RES_BYTES = (2 * DATA_W + 7) / 8;
  localparam int PW        = RES_BYTES * 8;
  localparam int DVW       = $clog2(CLK_DIV);
  localparam int BYW       = $clog2(RES_BYTES) + 1;

  logic                tx_q, tx_d;
  logic [DVW-1:0]      div_q, div_d;
  logic [3:0]          bit_q, bit_d;
  logic [BYW-1:0]      byte_q, byte_d;
  logic [7:0]          sh_q, sh_d;

  // Top byte is zero-padded when the result width is not a whole number of bytes.
  function automatic logic [7:0] byte_of(input logic [RW-1:0] v, input int unsigned k);
    logic [PW-1:0] p;
    p = PW'(v);
    return p[8*k +: 8];
  endfunction
`endif

  always_comb begin
    a_ext    = RW'(a_q);
    b_ext    = RW'(b_q);
    shamt    = 32'(b_q) % RW;
    exec_res = '0;
    case (op_q)
      OP_ADD:  exec_res = a_ext + b_ext;
      OP_SUB:  exec_res = a_ext - b_ext;
      OP_AND:  exec_res = a_ext & b_ext;
      OP_OR:   exec_res = a_ext | b_ext;
      OP_XOR:  exec_res = a_ext ^ b_ext;
      OP_SHL:  exec_res = a_ext << shamt;
      OP_CMP:  exec_res = (a_q == b_q) ? RW'(0) : ((a_q > b_q) ? RW'(1) : RW'(2));
      default: exec_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    mcnt_d   = mcnt_q;
    fin      = 1'b0;
    fin_res  = exec_res;
    mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
`ifdef JSILICON_UART_EN
    tx_d     = tx_q;
    div_d    = div_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    sh_d     = sh_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (ena && start) begin
          a_d    = a;
          b_d    = b;
          op_d   = opcode;
          busy_d = 1'b1;
          if (opcode == OP_MUL) begin
            state_d  = S_MUL;
            acc_d    = '0;
            mcand_d  = RW'(a);
            mplier_d = b;
            mcnt_d   = '0;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        fin     = 1'b1;
        fin_res = exec_res;
      end
      S_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        mcnt_d   = mcnt_q + 1'b1;
        if (mcnt_q == MCW'(DATA_W - 1)) begin
          fin     = 1'b1;
          fin_res = mul_sum;
        end
      end
`ifdef JSILICON_UART_EN
      S_TX: begin
        if (div_q == DVW'(CLK_DIV - 1)) begin
          div_d = '0;
          if (bit_q == 4'd9) begin
            bit_d = '0;
            if (byte_q == BYW'(RES_BYTES - 1)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              tx_d    = 1'b1;
              byte_d  = '0;
            end else begin
              // Next frame starts immediately after the stop bit, no idle gap.
              byte_d = byte_q + 1'b1;
              tx_d   = 1'b0;
              sh_d   = byte_of(result_q, 32'(byte_q) + 32'd1);
            end
          end else begin
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd8) begin
              tx_d = 1'b1;
            end else begin
              tx_d = sh_q[0];
              sh_d = sh_q >> 1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      result_d = fin_res;
`ifdef JSILICON_UART_EN
      state_d = S_TX;
      tx_d    = 1'b0;
      div_d   = '0;
      bit_d   = '0;
      byte_d  = '0;
      sh_d    = byte_of(fin_res, 32'd0);
`else
      state_d = S_DONE;
      done_d  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mcnt_q   <= '0;
`ifdef JSILICON_UART_EN
      tx_q     <= 1'b1;
      div_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      sh_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      mcnt_q   <= mcnt_d;
`ifdef JSILICON_UART_EN
      tx_q     <= tx_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      sh_q     <= sh_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
`ifdef JSILICON_UART_EN
  assign tx = tx_q;
`else
  assign tx = 1'b1;
`endif

endmodule
